match_sequencer: RTL and testbench
==================================

# match_sequencer

Parametrised N-player match controller for the cat-and-dog artillery game. It runs the turn order, launches throws, applies hit damage to per-player HP, skips eliminated players, generates a per-turn wind value and declares the winner. It sits between the input side (mouse/throw request, power) and the flight simulator/draw chain, and generalises the fixed two-player turn, wind and HP handling to N players with elimination and a flight timeout.

## Interface
- N_PLAYERS, 2: number of players, 2..8; PW = $clog2(N_PLAYERS)
- HP_W, 7: HP width per player
- HP_INIT, 100: starting HP, must fit HP_W
- WIND_W, 3: wind output width, 1..8
- FLIGHT_TIMEOUT, 600000: cycles in FLIGHT before forced miss
- clk60MHz  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin/restart match (level, sampled in IDLE/OVER)
- throw_req  in  1  current player fires (sampled in AIM)
- power  in  4  throw power, latched with throw_req
- hit_valid  in  1  single-cycle flight result from simulator
- hit_target  in  PW  player index hit
- hit_damage  in  HP_W  damage; 0 = miss
- throw_go  out  1  one-cycle launch pulse
- throw_power  out  4  latched power for the launched throw
- turn  out  PW  index of current player
- turn_count  out  8  completed turns, saturates at 255
- wind  out  WIND_W  wind for current turn
- hp  out  N_PLAYERS*HP_W  packed HP, player i at [i*HP_W +: HP_W]
- alive  out  N_PLAYERS  bit i = player i has HP > 0
- game_over  out  1  match finished
- winner  out  PW  winning player, valid while game_over

## Operation
- States: IDLE, AIM, FLIGHT, RESOLVE, NEXT, OVER.
- Reset (rst_n low, immediate): state IDLE; all outputs 0; hp all 0; alive 0; LFSR = 8'hA5.
- IDLE/OVER + start=1: all hp = HP_INIT, alive all 1, turn 0, turn_count 0, game_over 0, LFSR stepped once, wind = LFSR[WIND_W-1:0]; -> AIM.
- AIM: throw_req=1 -> throw_power <= power, throw_go pulse, timeout counter cleared; -> FLIGHT. hit_valid ignored.
- FLIGHT: throw_req ignored. hit_valid=1 -> if hit_target < N_PLAYERS and alive[hit_target]: hp[target] <= saturating hp - hit_damage (floor 0); else no change. -> RESOLVE. Counter reaching FLIGHT_TIMEOUT-1 without hit_valid -> RESOLVE as miss.
- RESOLVE (1 cycle): alive recomputed from hp (registered). Alive count <= 1 -> OVER, winner = lowest alive index (0 if none); else -> NEXT. Self-hit by the thrower allowed.
- NEXT (1 cycle): turn <= next alive index after turn, searching upward with wrap mod N_PLAYERS; turn_count += 1 (sat 255); LFSR stepped, wind updated; -> AIM.
- OVER: game_over=1, hp/alive/turn frozen; start restarts as in IDLE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left, feedback into bit 0; never all-zero.
- start outside IDLE/OVER ignored; reset mid-match returns to IDLE, throw_go never asserted by reset.

## Timing
- throw_go high exactly one cycle, the cycle after throw_req sampled in AIM; throw_power valid same cycle and held until next launch.
- hit_valid at cycle T -> hp updated at T+1 (state RESOLVE) -> alive updated and state OVER/NEXT at T+2 -> game_over high at T+2 if finishing; otherwise turn, turn_count, wind change at T+3 (state AIM).
- Earliest next throw_req accepted at T+3.
- Timeout: FLIGHT entered at cycle L -> RESOLVE at L+FLIGHT_TIMEOUT if no hit_valid.
- start in OVER at T -> hp reload and AIM at T+1.

## Test plan
- N=2, reset, start, throw_req with power=9 -> throw_go one-cycle pulse next cycle, throw_power=9, turn stays 0 until result.
- N=2, hit_valid target=1 damage=30 -> hp1=70 at T+1, turn=1, turn_count=1 at T+3, wind = new LFSR bits.
- N=2, hp1=20, hit damage=50 -> hp1=0 (saturated), alive=2'b01, game_over=1, winner=0 at T+2; further throw_req gives no throw_go.
- N=4, player 2 eliminated, turn=1 resolves miss -> turn=3; from turn=3 -> wraps to 0.
- FLIGHT_TIMEOUT=16, no hit_valid -> RESOLVE after 16 cycles, hp unchanged, turn advances.
- hit_target=5 with N=4, and hit on dead player -> hp unchanged; rst_n low mid-FLIGHT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/match_sequencer.sv
// match_sequencer: N-player artillery match controller. Runs the turn order,
// launches throws, applies damage, skips eliminated players, draws a per-turn
// wind value from an 8-bit LFSR and declares the winner.
module match_sequencer #(
    parameter int N_PLAYERS      = 2,
    parameter int HP_W           = 7,
    parameter int HP_INIT        = 100,
    parameter int WIND_W         = 3,
    parameter int FLIGHT_TIMEOUT = 600000
) (
    input  logic                          clk60MHz,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          throw_req,
    input  logic [3:0]                    power,
    input  logic                          hit_valid,
    input  logic [$clog2(N_PLAYERS)-1:0]  hit_target,
    input  logic [HP_W-1:0]               hit_damage,
    output logic                          throw_go,
    output logic [3:0]                    throw_power,
    output logic [$clog2(N_PLAYERS)-1:0]  turn,
    output logic [7:0]                    turn_count,
    output logic [WIND_W-1:0]             wind,
    output logic [N_PLAYERS*HP_W-1:0]     hp,
    output logic [N_PLAYERS-1:0]          alive,
    output logic                          game_over,
    output logic [$clog2(N_PLAYERS)-1:0]  winner
);
    localparam int PW = $clog2(N_PLAYERS);
    localparam int TW = $clog2(FLIGHT_TIMEOUT + 1);
    localparam logic [HP_W-1:0] HP_START     = HP_W'(HP_INIT);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(FLIGHT_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, AIM, FLIGHT, RESOLVE, NEXT, OVER} state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           lfsr;
    logic [7:0]           lfsr_step;
    logic [TW-1:0]        flight_cnt;
    logic [HP_W-1:0]      hp_arr [N_PLAYERS];
    logic [N_PLAYERS-1:0] alive_from_hp;
    int                   alive_count;
    logic [PW-1:0]        lowest_alive;
    logic [PW-1:0]        next_turn;
    logic [PW-1:0]        cand;
    logic                 turn_found;
    logic                 target_in_range;
    logic                 hit_applies;
    logic [HP_W-1:0]      target_hp;
    logic [HP_W-1:0]      hp_after_hit;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_hp_pack
        assign hp[g*HP_W +: HP_W] = hp_arr[g];
    end

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Damage of the current hit, floored at zero; only live, in-range targets take it
    always_comb begin
        target_in_range = int'(hit_target) < N_PLAYERS;
        target_hp       = target_in_range ? hp_arr[hit_target] : '0;
        hit_applies     = target_in_range && alive[hit_target];
        hp_after_hit    = (target_hp > hit_damage) ? (target_hp - hit_damage) : '0;
    end

    // Survivors as seen from the current HP: mask, head count and lowest index
    always_comb begin
        alive_from_hp = '0;
        alive_count   = 0;
        lowest_alive  = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (hp_arr[PW'(i)] != '0) begin
                alive_from_hp[PW'(i)] = 1'b1;
                alive_count           = alive_count + 1;
                lowest_alive          = PW'(i);
            end
        end
    end

    // Next living player after the current one, searching upward with wrap-around
    always_comb begin
        next_turn  = turn;
        turn_found = 1'b0;
        cand       = '0;
        for (int i = 1; i < N_PLAYERS; i++) begin
            cand = PW'((int'(turn) + i) % N_PLAYERS);
            if (!turn_found && alive[cand]) begin
                next_turn  = cand;
                turn_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; a hit wins over a simultaneous timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER: if (start) state_next = AIM;
            AIM:        if (throw_req) state_next = FLIGHT;
            FLIGHT:     if (hit_valid || flight_cnt == TIMEOUT_LAST) state_next = RESOLVE;
            RESOLVE:    state_next = (alive_count <= 1) ? OVER : NEXT;
            NEXT:       state_next = AIM;
            default:    state_next = IDLE;
        endcase
    end

    // Match datapath: HP, alive mask, turn bookkeeping, wind and launch pulse
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            throw_go    <= 1'b0;
            throw_power <= '0;
            turn        <= '0;
            turn_count  <= '0;
            wind        <= '0;
            alive       <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
            lfsr        <= 8'hA5;
            flight_cnt  <= '0;
            hp_arr      <= '{default: '0};
        end else begin
            throw_go <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        hp_arr     <= '{default: HP_START};
                        alive      <= '1;
                        turn       <= '0;
                        turn_count <= '0;
                        game_over  <= 1'b0;
                        lfsr       <= lfsr_step;
                        wind       <= lfsr_step[WIND_W-1:0];
                    end
                end
                AIM: begin
                    if (throw_req) begin
                        throw_power <= power;
                        throw_go    <= 1'b1;
                        flight_cnt  <= '0;
                    end
                end
                FLIGHT: begin
                    if (hit_valid) begin
                        if (hit_applies) begin
                            hp_arr[hit_target] <= hp_after_hit;
                        end
                    end else begin
                        flight_cnt <= flight_cnt + 1'b1;
                    end
                end
                RESOLVE: begin
                    alive <= alive_from_hp;
                    if (alive_count <= 1) begin
                        game_over <= 1'b1;
                        winner    <= lowest_alive;
                    end
                end
                NEXT: begin
                    turn <= next_turn;
                    if (turn_count != 8'hFF) begin
                        turn_count <= turn_count + 1'b1;
                    end
                    lfsr <= lfsr_step;
                    wind <= lfsr_step[WIND_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed scenarios plus random play for a 3-player
// match, checked every cycle against a behavioural model of the match rules.
module tb_match_sequencer;
    localparam int N       = 3;
    localparam int HP_W    = 7;
    localparam int HP_INIT = 100;
    localparam int WIND_W  = 3;
    localparam int FT      = 16;
    localparam int PW      = $clog2(N);

    localparam int M_IDLE    = 0;
    localparam int M_AIM     = 1;
    localparam int M_FLIGHT  = 2;
    localparam int M_RESOLVE = 3;
    localparam int M_NEXT    = 4;
    localparam int M_OVER    = 5;

    logic              clk60MHz = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              throw_req = 1'b0;
    logic [3:0]        power = '0;
    logic              hit_valid = 1'b0;
    logic [PW-1:0]     hit_target = '0;
    logic [HP_W-1:0]   hit_damage = '0;
    logic              throw_go;
    logic [3:0]        throw_power;
    logic [PW-1:0]     turn;
    logic [7:0]        turn_count;
    logic [WIND_W-1:0] wind;
    logic [N*HP_W-1:0] hp;
    logic [N-1:0]      alive;
    logic              game_over;
    logic [PW-1:0]     winner;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the match as the rules describe it
    int m_phase  = M_IDLE;
    int m_hp[N];
    int m_alive[N];
    int m_turn   = 0;
    int m_tc     = 0;
    int m_wind   = 0;
    int m_lfsr   = 'hA5;
    int m_power  = 0;
    int m_go     = 0;
    int m_over   = 0;
    int m_winner = 0;
    int m_flown  = 0;

    always #5 clk60MHz = ~clk60MHz;

    match_sequencer #(
        .N_PLAYERS(N), .HP_W(HP_W), .HP_INIT(HP_INIT),
        .WIND_W(WIND_W), .FLIGHT_TIMEOUT(FT)
    ) dut (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .start(start),
        .throw_req(throw_req), .power(power), .hit_valid(hit_valid),
        .hit_target(hit_target), .hit_damage(hit_damage),
        .throw_go(throw_go), .throw_power(throw_power), .turn(turn),
        .turn_count(turn_count), .wind(wind), .hp(hp), .alive(alive),
        .game_over(game_over), .winner(winner)
    );

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    function automatic logic [N-1:0] model_alive_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_alive[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        for (int i = 0; i < N; i++) begin
            m_hp[i]    = 0;
            m_alive[i] = 0;
        end
        m_turn = 0; m_tc = 0; m_wind = 0; m_lfsr = 'hA5; m_power = 0;
        m_go = 0; m_over = 0; m_winner = 0; m_flown = 0;
    endtask

    task automatic model_step();
        int t;
        int living;
        int pick;
        bit found;
        m_go = 0;
        case (m_phase)
            M_IDLE, M_OVER: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        m_hp[i]    = HP_INIT;
                        m_alive[i] = 1;
                    end
                    m_turn = 0; m_tc = 0; m_over = 0;
                    m_lfsr  = lfsr_next(m_lfsr);
                    m_wind  = m_lfsr % (1 << WIND_W);
                    m_phase = M_AIM;
                end
            end
            M_AIM: begin
                if (throw_req) begin
                    m_power = int'(power);
                    m_go    = 1;
                    m_flown = 0;
                    m_phase = M_FLIGHT;
                end
            end
            M_FLIGHT: begin
                m_flown++;
                if (hit_valid) begin
                    t = int'(hit_target);
                    if (t < N) begin
                        if (m_alive[t] != 0) begin
                            m_hp[t] = (m_hp[t] > int'(hit_damage)) ? m_hp[t] - int'(hit_damage) : 0;
                        end
                    end
                    m_phase = M_RESOLVE;
                end else if (m_flown == FT) begin
                    m_phase = M_RESOLVE;
                end
            end
            M_RESOLVE: begin
                living = 0;
                m_winner = 0;
                found = 0;
                for (int i = 0; i < N; i++) begin
                    m_alive[i] = (m_hp[i] > 0) ? 1 : 0;
                    living += m_alive[i];
                    if (!found && m_alive[i] != 0) begin
                        m_winner = i;
                        found = 1;
                    end
                end
                if (living <= 1) begin
                    m_over  = 1;
                    m_phase = M_OVER;
                end else begin
                    m_phase = M_NEXT;
                end
            end
            M_NEXT: begin
                found = 0;
                for (int s = 1; s < N; s++) begin
                    pick = (m_turn + s) % N;
                    if (!found && m_alive[pick] != 0) begin
                        m_turn = pick;
                        found = 1;
                    end
                end
                m_tc    = (m_tc < 255) ? m_tc + 1 : 255;
                m_lfsr  = lfsr_next(m_lfsr);
                m_wind  = m_lfsr % (1 << WIND_W);
                m_phase = M_AIM;
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    // Advance the model on the same edges the design reacts to
    always @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic tr, input logic [3:0] pw,
                                 input logic hv, input logic [PW-1:0] tgt, input logic [HP_W-1:0] dmg);
        start = st; throw_req = tr; power = pw;
        hit_valid = hv; hit_target = tgt; hit_damage = dmg;
        @(negedge clk60MHz);
        start = 1'b0; throw_req = 1'b0; power = '0;
        hit_valid = 1'b0; hit_target = '0; hit_damage = '0;
    endtask

    task automatic pulseReset();
        @(posedge clk60MHz);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_throw_go", throw_go, 0);
        checkOutput("rst_throw_power", throw_power, 0);
        checkOutput("rst_hp", hp, 0);
        checkOutput("rst_alive", alive, 0);
        checkOutput("rst_turn_count", turn_count, 0);
        checkOutput("rst_wind", wind, 0);
        @(negedge clk60MHz);
        rst_n = 1'b1;
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk60MHz) begin
        checkOutput("throw_go", throw_go, m_go);
        checkOutput("throw_power", throw_power, m_power);
        checkOutput("turn", turn, m_turn);
        checkOutput("turn_count", turn_count, m_tc);
        checkOutput("wind", wind, m_wind);
        checkOutput("alive", alive, model_alive_vec());
        checkOutput("game_over", game_over, m_over);
        for (int i = 0; i < N; i++) begin
            checkOutput("hp", hp[i*HP_W +: HP_W], m_hp[i]);
        end
        if (m_over != 0) checkOutput("winner", winner, m_winner);
    end

    // Directed scenarios with hand-computed values, then random play
    initial begin
        logic [N*HP_W-1:0] full_hp;
        logic              r_st;
        logic              r_tr;
        logic              r_hv;
        logic [3:0]        r_pw;
        logic [PW-1:0]     r_tgt;
        logic [HP_W-1:0]   r_dmg;
        full_hp = {7'd100, 7'd100, 7'd100};

        repeat (3) @(negedge clk60MHz);
        checkOutput("reset_hp", hp, 0);
        checkOutput("reset_alive", alive, 0);
        checkOutput("reset_game_over", game_over, 0);
        checkOutput("reset_throw_go", throw_go, 0);
        rst_n = 1'b1;
        @(negedge clk60MHz);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("start_wind", wind, 2);
        checkOutput("start_hp", hp, full_hp);
        checkOutput("start_alive", alive, 3'b111);
        checkOutput("start_turn", turn, 0);

        applyStimulus(0, 1, 9, 0, 0, 0);
        checkOutput("launch_go", throw_go, 1);
        checkOutput("launch_power", throw_power, 9);
        @(negedge clk60MHz);
        checkOutput("launch_go_drop", throw_go, 0);
        checkOutput("launch_turn_hold", turn, 0);

        applyStimulus(0, 0, 0, 1, 1, 30);
        checkOutput("hit_hp1", hp[HP_W +: HP_W], 70);
        repeat (2) @(negedge clk60MHz);
        checkOutput("hit_turn", turn, 1);
        checkOutput("hit_turn_count", turn_count, 1);
        checkOutput("hit_wind", wind, 5);

        applyStimulus(0, 1, 3, 0, 0, 0);
        repeat (FT - 1) @(negedge clk60MHz);
        checkOutput("timeout_early_turn", turn, 1);
        repeat (3) @(negedge clk60MHz);
        checkOutput("timeout_turn", turn, 2);
        checkOutput("timeout_hp", hp, {7'd100, 7'd70, 7'd100});
        checkOutput("timeout_wind", wind, 2);

        applyStimulus(0, 1, 5, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3, 50);
        checkOutput("oob_hp", hp, {7'd100, 7'd70, 7'd100});
        repeat (2) @(negedge clk60MHz);
        checkOutput("wrap_turn", turn, 0);
        checkOutput("wrap_wind", wind, 4);

        applyStimulus(0, 1, 7, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 80);
        checkOutput("sat_hp1", hp[HP_W +: HP_W], 0);
        @(negedge clk60MHz);
        checkOutput("elim_alive", alive, 3'b101);
        @(negedge clk60MHz);
        checkOutput("skip_turn", turn, 2);
        checkOutput("skip_turn_count", turn_count, 4);
        checkOutput("skip_wind", wind, 1);

        applyStimulus(0, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 10);
        checkOutput("dead_hit_hp", hp, {7'd100, 7'd0, 7'd100});
        repeat (2) @(negedge clk60MHz);
        checkOutput("dead_wrap_turn", turn, 0);
        checkOutput("dead_wrap_wind", wind, 3);

        applyStimulus(0, 1, 15, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 2, 127);
        @(negedge clk60MHz);
        checkOutput("over_flag", game_over, 1);
        checkOutput("over_alive", alive, 3'b001);
        checkOutput("over_winner", winner, 0);
        applyStimulus(0, 1, 4, 0, 0, 0);
        checkOutput("over_no_launch", throw_go, 0);
        checkOutput("over_power_hold", throw_power, 15);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("restart_hp", hp, full_hp);
        checkOutput("restart_game_over", game_over, 0);
        checkOutput("restart_turn_count", turn_count, 0);
        checkOutput("restart_wind", wind, 7);

        applyStimulus(0, 1, 6, 0, 0, 0);
        @(negedge clk60MHz);
        pulseReset();

        for (int c = 0; c < 3000; c++) begin
            if (m_phase == M_IDLE || m_phase == M_OVER) r_st = ($urandom_range(0, 3) == 0);
            else r_st = ($urandom_range(0, 15) == 0);
            r_tr  = ($urandom_range(0, 2) == 0);
            r_hv  = ($urandom_range(0, 6) == 0);
            r_pw  = 4'($urandom_range(0, 15));
            r_tgt = PW'($urandom_range(0, 3));
            r_dmg = ($urandom_range(0, 1) == 0) ? HP_W'($urandom_range(0, 127)) : HP_W'($urandom_range(0, 35));
            applyStimulus(r_st, r_tr, r_pw, r_hv, r_tgt, r_dmg);
            if (c % 1000 == 999) pulseReset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
